vector_capture: RTL and testbench
=================================

Name: vector_capture

Overview:
- Synthesizable response recorder: the writer side of the test-vector flow.
- Captures {inputs, observed output} samples from a DUT (e.g. {a,b,c,y} of the minority gate) into an on-chip buffer while the DUT runs.
- Drains the buffer as a valid/ready stream to a host, UART bridge or checker, producing a vector file in the same format our benches read back.

Parameters:
- WIDTH, 4, bits per captured vector ({a,b,c,y}).
- DEPTH, 32, buffer entries. Must be a power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of count. Derived; not to be overridden.

Ports:
- clk        input   1      rising-edge clock.
- reset      input   1      asynchronous, active-high reset.
- start      input   1      one-cycle pulse that begins a capture session. Honoured only in IDLE.
- stop       input   1      ends capture early. Honoured only in CAPTURE.
- sample_en  input   1      write vec_in this cycle. Honoured only in CAPTURE.
- vec_in     input   WIDTH  vector to record.
- rd_valid   output  1      rd_data holds an unread entry.
- rd_ready   input   1      consumer accepts rd_data this cycle.
- rd_data    output  WIDTH  buffer entry at the read pointer.
- count      output  CW     number of entries captured this session.
- full       output  1      count == DEPTH.
- busy       output  1      state != IDLE.
- done       output  1      one-cycle pulse when a session completes.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; wr_ptr=0, rd_ptr=0, count=0.
  - rd_valid=0, full=0, busy=0, done=0, rd_data=0.
  - Buffer contents are not reset.
- FSM states: IDLE, CAPTURE, DRAIN.
- IDLE:
  - start=1 -> CAPTURE next cycle; wr_ptr, rd_ptr and count cleared on the same edge.
  - sample_en, stop and rd_ready are ignored.
  - count and full hold their last session values until the next start.
- CAPTURE:
  - Each cycle with sample_en=1: mem[wr_ptr] <= vec_in, wr_ptr++, count++.
  - count updates on the same edge as the write.
  - On the edge where count becomes DEPTH: full=1, state -> DRAIN. A sample_en in the following cycle is not written.
  - stop=1 with count>0 (including a same-cycle write) -> DRAIN.
  - stop=1 and sample_en=1 in the same cycle: the sample is written first, then DRAIN.
  - stop=1 with count==0 and no same-cycle write -> IDLE; done pulses on the next cycle.
  - start is ignored.
- DRAIN:
  - rd_valid = (rd_ptr < count).
  - rd_data = mem[rd_ptr], combinational read. It stays stable while rd_valid=1 and rd_ready=0.
  - A transfer happens on a cycle with rd_valid & rd_ready; rd_ptr++ on that edge.
  - One transfer per cycle at most. A back-to-back ready drains one entry per clock.
  - After the transfer with rd_ptr == count-1: state -> IDLE, and rd_valid=0 from the next cycle.
  - done=1 for exactly the first IDLE cycle after that transfer.
  - rd_ready while rd_valid=0 has no effect. start, stop and sample_en are ignored.
- Outputs:
  - rd_data is driven 0 whenever rd_valid=0.
  - busy=1 in CAPTURE and DRAIN.
- Pointer widths: the pointers are $clog2(DEPTH) bits wide. A capture of DEPTH entries never wraps because the FSM leaves CAPTURE at full.
- Latency:
  - A sample written on edge N is counted on edge N.
  - The first rd_valid appears in the cycle after entering DRAIN.
- Reset mid-session (CAPTURE or DRAIN): immediate return to IDLE with all outputs at reset values. Any partial session is discarded; done is not pulsed.

Test Plan:
1. Reset, start, then 8 consecutive sample_en with vec_in = the minority truth table {0001,0011,0101,0110,1001,1010,1100,1110}, then stop -> count=8, rd_valid rises. With rd_ready=1, rd_data reads the 8 vectors in order on 8 consecutive cycles, followed by a 1-cycle done pulse, busy=0 and count still 8.
2. 32 samples with vec_in = index[3:0], sample_en held through cycle 40 -> full=1 after the 32nd write, no 33rd write, count=32. Drain returns 0..15,0..15.
3. Backpressure: 3 entries {1010,0101,1111}, rd_ready toggling 0,0,1,0,1,1 -> rd_data holds 1010 during both stall cycles. Exactly 3 transfers occur, in order.
4. start then stop with no samples -> busy returns to 0, done pulses once, rd_valid never asserts, count=0.
5. stop and sample_en in the same cycle with vec_in=0110 after 2 samples -> count=3 and the last entry drained is 0110.
6. Reset asserted asynchronously (mid-cycle) after 2 of 5 entries are drained -> all outputs 0 immediately and no done pulse. A new start/2-sample session then drains exactly 2 entries.

Source files
------------

// File: rtl/vector_capture.sv
// Response recorder: captures DUT vectors into a buffer during a session,
// then drains them in order over a valid/ready stream.
module vector_capture #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] vec_in,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             busy,
    output logic             done
);

    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [1:0]       state;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_write;
    logic             do_read;

    assign do_write = (state == CAPTURE) && sample_en;
    assign rd_valid = (state == DRAIN) && ({1'b0, rd_ptr} < count);
    assign do_read  = rd_valid && rd_ready;
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign full     = (count == DEPTH_C);
    assign busy     = (state != IDLE);

    // Buffer storage carries no reset; stale entries are never exposed
    // because rd_valid only covers entries written this session.
    always_ff @(posedge clk) begin
        if (do_write)
            mem[wr_ptr] <= vec_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CAPTURE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                        count  <= '0;
                    end
                end
                CAPTURE: begin
                    if (do_write) begin
                        wr_ptr <= wr_ptr + PW'(1);
                        count  <= count + ONE_C;
                    end
                    // The write that fills the buffer forces DRAIN, so the
                    // pointers never wrap within a session.
                    if (do_write && (count == DEPTH_C - ONE_C)) begin
                        state <= DRAIN;
                    end else if (stop) begin
                        if (do_write || (count != '0)) begin
                            state <= DRAIN;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (do_read) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        if ({1'b0, rd_ptr} == count - ONE_C) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_capture.sv
// Self-checking bench for vector_capture: expected vectors are queued when
// captured and popped as the drain stream delivers them.
module tb_vector_capture;

    localparam int WIDTH = 4;
    localparam int DEPTH = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             start;
    logic             stop;
    logic             sample_en;
    logic [WIDTH-1:0] vec_in;
    logic             rd_valid;
    logic             rd_ready;
    logic [WIDTH-1:0] rd_data;
    logic [CW-1:0]    count;
    logic             full;
    logic             busy;
    logic             done;

    int passed = 0;
    int total  = 0;

    logic [WIDTH-1:0] exp_q [$];

    vector_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .sample_en (sample_en),
        .vec_in    (vec_in),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs change and outputs
    // are sampled here, one time unit clear of the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [WIDTH-1:0] v);
        sample_en = 1'b1;
        vec_in    = v;
        exp_q.push_back(v);
        tick();
        sample_en = 1'b0;
    endtask

    task automatic begin_session();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_session();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Drain at full rate; any stall beyond the queue length is a failure.
    task automatic drain_queue(input int budget);
        logic [WIDTH-1:0] exp_v;
        int cycles = 0;
        rd_ready = 1'b1;
        while (exp_q.size() > 0 && cycles < budget) begin
            total++;
            if (rd_valid !== 1'b1) begin
                $display("[TB] FAIL drain_valid: rd_valid=%b required 1 (cycle %0d)", rd_valid, cycles);
            end else begin
                passed++;
                exp_v = exp_q.pop_front();
                total++;
                if (rd_data !== exp_v)
                    $display("[TB] FAIL drain_data: rd_data=%b required %b", rd_data, exp_v);
                else
                    passed++;
            end
            tick();
            cycles++;
        end
        rd_ready = 1'b0;
        total++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL drain_budget: %0d entries left, required 0", exp_q.size());
        else
            passed++;
        exp_q.delete();
        total++;
        if ({done, busy, rd_valid} !== 3'b100)
            $display("[TB] FAIL drain_end: done/busy/rd_valid=%b required 100", {done, busy, rd_valid});
        else
            passed++;
        total++;
        if (rd_data !== '0)
            $display("[TB] FAIL drain_idle_data: rd_data=%b required 0000", rd_data);
        else
            passed++;
        tick();
        total++;
        if (done !== 1'b0)
            $display("[TB] FAIL done_width: done=%b required 0", done);
        else
            passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; stop = 0; sample_en = 0; vec_in = '0; rd_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({rd_valid, full, busy, done} !== 4'b0000 || count !== '0 || rd_data !== '0)
            $display("[TB] FAIL reset_state: valid/full/busy/done=%b count=%0d data=%b required 0000/0/0000",
                     {rd_valid, full, busy, done}, count, rd_data);
        else
            passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_minority();
        logic [WIDTH-1:0] tt [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b0110,
                                     4'b1001, 4'b1010, 4'b1100, 4'b1110};
        begin_session();
        total++;
        if (busy !== 1'b1 || count !== '0)
            $display("[TB] FAIL capture_entry: busy=%b count=%0d required 1/0", busy, count);
        else
            passed++;
        for (int i = 0; i < 8; i++) capture(tt[i]);
        end_session();
        total++;
        if (count !== CW'(8) || rd_valid !== 1'b1 || full !== 1'b0)
            $display("[TB] FAIL minority_count: count=%0d valid=%b full=%b required 8/1/0", count, rd_valid, full);
        else
            passed++;
        drain_queue(8);
        total++;
        if (count !== CW'(8))
            $display("[TB] FAIL count_hold: count=%0d required 8", count);
        else
            passed++;
    endtask

    task automatic test_full();
        begin_session();
        sample_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            vec_in = WIDTH'(i);
            if (i < DEPTH) exp_q.push_back(WIDTH'(i));
            tick();
            if (i == DEPTH - 1) begin
                total++;
                if (full !== 1'b1 || count !== CW'(DEPTH) || busy !== 1'b1)
                    $display("[TB] FAIL full_flag: full=%b count=%0d busy=%b required 1/32/1", full, count, busy);
                else
                    passed++;
            end
        end
        sample_en = 1'b0;
        total++;
        if (count !== CW'(DEPTH) || rd_data !== 4'h0)
            $display("[TB] FAIL no_overwrite: count=%0d rd_data=%b required 32/0000", count, rd_data);
        else
            passed++;
        drain_queue(DEPTH);
        total++;
        if (full !== 1'b1)
            $display("[TB] FAIL full_hold: full=%b required 1", full);
        else
            passed++;
    endtask

    task automatic test_back_to_back_backpressure();
        logic pat [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [WIDTH-1:0] exp_v;
        int xfers = 0;
        begin_session();
        capture(4'b1010);
        capture(4'b0101);
        capture(4'b1111);
        end_session();
        for (int k = 0; k < 6; k++) begin
            rd_ready = pat[k];
            if (k < 2) begin
                total++;
                if (rd_valid !== 1'b1 || rd_data !== 4'b1010)
                    $display("[TB] FAIL stall_hold: valid=%b data=%b required 1/1010", rd_valid, rd_data);
                else
                    passed++;
            end
            if (rd_valid && rd_ready) begin
                xfers++;
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                total++;
                if (rd_data !== exp_v)
                    $display("[TB] FAIL bp_data: rd_data=%b required %b", rd_data, exp_v);
                else
                    passed++;
            end
            tick();
        end
        rd_ready = 1'b0;
        exp_q.delete();
        total++;
        if (xfers != 3 || done !== 1'b1 || busy !== 1'b0)
            $display("[TB] FAIL bp_transfers: xfers=%0d done=%b busy=%b required 3/1/0", xfers, done, busy);
        else
            passed++;
        tick();
    endtask

    task automatic test_empty_session();
        begin_session();
        total++;
        if (rd_valid !== 1'b0)
            $display("[TB] FAIL empty_valid: rd_valid=%b required 0", rd_valid);
        else
            passed++;
        end_session();
        total++;
        if ({done, busy, rd_valid} !== 3'b100 || count !== '0)
            $display("[TB] FAIL empty_stop: done/busy/valid=%b count=%0d required 100/0", {done, busy, rd_valid}, count);
        else
            passed++;
        tick();
        total++;
        if (done !== 1'b0 || rd_valid !== 1'b0)
            $display("[TB] FAIL empty_done_once: done=%b valid=%b required 0/0", done, rd_valid);
        else
            passed++;
    endtask

    task automatic test_stop_with_sample();
        begin_session();
        capture(4'b0001);
        capture(4'b0011);
        sample_en = 1'b1;
        stop      = 1'b1;
        vec_in    = 4'b0110;
        exp_q.push_back(4'b0110);
        tick();
        sample_en = 1'b0;
        stop      = 1'b0;
        total++;
        if (count !== CW'(3) || busy !== 1'b1)
            $display("[TB] FAIL stop_write_count: count=%0d busy=%b required 3/1", count, busy);
        else
            passed++;
        drain_queue(3);
    endtask

    task automatic test_mid_reset();
        logic [WIDTH-1:0] exp_v;
        begin_session();
        for (int i = 0; i < 5; i++) capture(WIDTH'(4'h8 + i));
        end_session();
        rd_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_v = exp_q.pop_front();
            total++;
            if (rd_valid !== 1'b1 || rd_data !== exp_v)
                $display("[TB] FAIL pre_reset_data: valid=%b data=%b required 1/%b", rd_valid, rd_data, exp_v);
            else
                passed++;
            tick();
        end
        exp_q.delete();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({rd_valid, full, busy, done} !== 4'b0000 || count !== '0 || rd_data !== '0)
            $display("[TB] FAIL async_reset: valid/full/busy/done=%b count=%0d data=%b required 0000/0/0000",
                     {rd_valid, full, busy, done}, count, rd_data);
        else
            passed++;
        rd_ready = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (done !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL reset_no_done: done=%b busy=%b required 0/0", done, busy);
            else
                passed++;
            tick();
        end
        begin_session();
        capture(4'b0111);
        capture(4'b1011);
        end_session();
        total++;
        if (count !== CW'(2))
            $display("[TB] FAIL post_reset_count: count=%0d required 2", count);
        else
            passed++;
        drain_queue(2);
    endtask

    initial begin
        test_reset();
        test_minority();
        test_full();
        test_back_to_back_backpressure();
        test_empty_session();
        test_stop_with_sample();
        test_mid_reset();
        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
